sprite_anim_bitmap: RTL and testbench



---
 rtl/sprite_anim_bitmap_pkg.sv | 41 ++++
 rtl/sprite_anim_bitmap_if.sv | 21 ++
 rtl/sprite_anim_bitmap_ctrl.sv | 130 +++++++++++++
 rtl/sprite_anim_bitmap.sv | 87 ++++++++
 tb/tb_sprite_anim_bitmap.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_anim_bitmap_pkg.sv
// Shared types and constants for the animated sprite bitmap: animation modes,
// controller states, RGB332 pixel type and the image pattern generator.
package sprite_pkg;

   typedef enum logic [1:0] {
      ANIM_STATIC   = 2'b00,
      ANIM_LOOP     = 2'b01,
      ANIM_PINGPONG = 2'b10,
      ANIM_ONESHOT  = 2'b11
   } anim_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } anim_state_t;

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } anim_dir_t;

   typedef logic [7:0] rgb332_t;

   localparam rgb332_t TRANSPARENT_ENCODING = 8'hFF;
   localparam int      FRAME_IDX_W          = 4;
   localparam int      COORD_W              = 11;
   localparam int      HOLD_W               = 8;

   // Image content: frame number in the red bits, row/col in green/blue, with a
   // transparent main diagonal. The pattern repeats every 16 source pixels.
   function automatic rgb332_t rom_pixel(input logic [3:0] frame,
                                         input logic [3:0] row,
                                         input logic [3:0] col);
      rgb332_t px;
      px = {frame[1:0] ^ frame[3:2], row[2:0], col[2:0]};
      if (row == col) px = TRANSPARENT_ENCODING;
      return px;
   endfunction

endpackage

// File: rtl/sprite_anim_bitmap_if.sv
// Pixel bus between the rectangle/position block (master) and the sprite (slave).
interface sprite_anim_bitmap_if;
   import sprite_pkg::*;

   logic [COORD_W-1:0] offsetX;
   logic [COORD_W-1:0] offsetY;
   logic               InsideRectangle;
   logic               drawingRequest;
   rgb332_t            RGBout;

   modport master (
      output offsetX, offsetY, InsideRectangle,
      input  drawingRequest, RGBout
   );

   modport slave (
      input  offsetX, offsetY, InsideRectangle,
      output drawingRequest, RGBout
   );

endinterface

// File: rtl/sprite_anim_bitmap_ctrl.sv
// Animation controller: frame sequencing (static/loop/ping-pong/one-shot) and
// hit-blink timer, both stepped only on video-frame ticks.
module sprite_anim_ctrl
   import sprite_pkg::*;
#(
   parameter int NUM_FRAMES   = 4,
   parameter int FRAME_HOLD   = 8,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   start_of_frame,
   input  anim_mode_t             anim_mode,
   input  logic                   restart,
   input  logic                   hit,
   output logic [FRAME_IDX_W-1:0] frame_idx,
   output logic                   blank_blink,
   output logic                   anim_done
);

   localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);
   localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
   localparam logic [HOLD_W-1:0]      BLINK_LOAD = HOLD_W'(BLINK_FRAMES);

   anim_state_t            state_q, state_d;
   logic [FRAME_IDX_W-1:0] frame_q, frame_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   anim_dir_t              dir_q, dir_d;
   logic [HOLD_W-1:0]      blink_q, blink_d;
   logic [FRAME_IDX_W-1:0] frame_inc;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d   = state_q;
      frame_d   = frame_q;
      hold_d    = hold_q;
      dir_d     = dir_q;
      blink_d   = blink_q;
      frame_inc = (frame_q == LAST_FRAME) ? frame_q : frame_q + 4'd1;

      if (restart) begin
         state_d = ST_IDLE;
         frame_d = '0;
         hold_d  = '0;
         dir_d   = DIR_UP;
      end else if (start_of_frame) begin
         if (anim_mode == ANIM_STATIC) begin
            state_d = ST_IDLE;
            frame_d = '0;
            hold_d  = '0;
            dir_d   = DIR_UP;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_RUN;
                  frame_d = '0;
                  hold_d  = '0;
                  dir_d   = DIR_UP;
               end
               ST_RUN: begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d = '0;
                     case (anim_mode)
                        ANIM_LOOP: frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 4'd1;
                        ANIM_PINGPONG: begin
                           // A single-image sprite has nowhere to bounce to.
                           if (NUM_FRAMES > 1) begin
                              if (dir_q == DIR_UP) begin
                                 if (frame_q == LAST_FRAME) begin
                                    dir_d   = DIR_DOWN;
                                    frame_d = frame_q - 4'd1;
                                 end else begin
                                    frame_d = frame_q + 4'd1;
                                 end
                              end else begin
                                 if (frame_q == '0) begin
                                    dir_d   = DIR_UP;
                                    frame_d = frame_q + 4'd1;
                                 end else begin
                                    frame_d = frame_q - 4'd1;
                                 end
                              end
                           end
                        end
                        ANIM_ONESHOT: begin
                           frame_d = frame_inc;
                           if (frame_inc == LAST_FRAME) state_d = ST_DONE;
                        end
                        default: frame_d = frame_q;
                     endcase
                  end else begin
                     hold_d = hold_q + 8'd1;
                  end
               end
               ST_DONE: state_d = ST_DONE;
               default: state_d = ST_IDLE;
            endcase
         end
      end

      // A fresh hit reloads rather than accumulates.
      if (hit) begin
         blink_d = BLINK_LOAD;
      end else if (start_of_frame && (blink_q != '0)) begin
         blink_d = blink_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= ST_IDLE;
         frame_q <= '0;
         hold_q  <= '0;
         dir_q   <= DIR_UP;
         blink_q <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hold_q  <= hold_d;
         dir_q   <= dir_d;
         blink_q <= blink_d;
      end
   end

   assign frame_idx   = frame_q;
   assign anim_done   = (state_q == ST_DONE);
   assign blank_blink = (blink_q != '0) && blink_q[2];

endmodule

// File: rtl/sprite_anim_bitmap.sv
// Animated sprite bitmap: scaled pixel addressing, image lookup and one output
// register stage. Define SPRITE_MIRROR_EN to enable the mirrorX horizontal flip.
module sprite_anim_bitmap
   import sprite_pkg::*;
#(
   parameter int OBJECT_WIDTH_X  = 16,
   parameter int OBJECT_HEIGHT_Y = 16,
   parameter int SCALE_SHIFT     = 1,
   parameter int NUM_FRAMES      = 4,
   parameter int FRAME_HOLD      = 8,
   parameter int BLINK_FRAMES    = 32
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 hide,
   input  logic [1:0]           animMode,
   input  logic                 restart,
   input  logic                 hit,
   input  logic                 mirrorX,
   output logic                 animDone,
   sprite_anim_bitmap_if.slave  pix
);

   localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(OBJECT_WIDTH_X);
   localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(OBJECT_HEIGHT_Y);

   logic [FRAME_IDX_W-1:0] frame_idx;
   logic                   blank_blink;
   logic [COORD_W-1:0]     col_raw;
   logic [COORD_W-1:0]     row;
   logic [3:0]             col;
   logic                   in_range;
   rgb332_t                pix_val;
   rgb332_t                rgb_q, rgb_d;
   logic                   req_q, req_d;

   sprite_anim_ctrl #(
      .NUM_FRAMES   (NUM_FRAMES),
      .FRAME_HOLD   (FRAME_HOLD),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_ctrl (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (startOfFrame),
      .anim_mode      (anim_mode_t'(animMode)),
      .restart        (restart),
      .hit            (hit),
      .frame_idx      (frame_idx),
      .blank_blink    (blank_blink),
      .anim_done      (animDone)
   );

   assign col_raw  = pix.offsetX >> SCALE_SHIFT;
   assign row      = pix.offsetY >> SCALE_SHIFT;
   // Range is judged on the unflipped column so mirroring never wraps into view.
   assign in_range = (col_raw < WIDTH_C) && (row < HEIGHT_C);

`ifdef SPRITE_MIRROR_EN
   assign col = mirrorX ? 4'(WIDTH_C - 11'd1 - col_raw) : col_raw[3:0];
`else
   logic unused_mirror;
   assign unused_mirror = mirrorX;
   assign col           = col_raw[3:0];
`endif

   always_comb begin
      pix_val = in_range ? rom_pixel(frame_idx, row[3:0], col) : TRANSPARENT_ENCODING;
      rgb_d   = pix.InsideRectangle ? pix_val : TRANSPARENT_ENCODING;
      req_d   = pix.InsideRectangle && (pix_val != TRANSPARENT_ENCODING)
                && !hide && !blank_blink;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rgb_q <= TRANSPARENT_ENCODING;
         req_q <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         req_q <= req_d;
      end
   end

   assign pix.RGBout         = rgb_q;
   assign pix.drawingRequest = req_q;

endmodule

// File: tb/tb_sprite_anim_bitmap.sv
// Directed bench for sprite_anim_bitmap: three instances cover FRAME_HOLD=2,
// FRAME_HOLD=1 and NUM_FRAMES=1; all share stimulus.
module tb_sprite_anim_bitmap;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetN, sof, hide, restart, hit, mirrorX;
   logic [1:0] mode;
   logic       done_a, done_b, done_c;
   int         n_cmp = 0;
   int         n_mis = 0;

   sprite_anim_bitmap_if bus_a ();
   sprite_anim_bitmap_if bus_b ();
   sprite_anim_bitmap_if bus_c ();

   sprite_anim_bitmap #(.NUM_FRAMES(4), .FRAME_HOLD(2), .BLINK_FRAMES(8)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .hide(hide), .animMode(mode),
      .restart(restart), .hit(hit), .mirrorX(mirrorX), .animDone(done_a), .pix(bus_a));

   sprite_anim_bitmap #(.NUM_FRAMES(4), .FRAME_HOLD(1), .BLINK_FRAMES(8)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .hide(hide), .animMode(mode),
      .restart(restart), .hit(hit), .mirrorX(mirrorX), .animDone(done_b), .pix(bus_b));

   sprite_anim_bitmap #(.NUM_FRAMES(1), .FRAME_HOLD(1), .BLINK_FRAMES(8)) dut_c (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .hide(hide), .animMode(mode),
      .restart(restart), .hit(hit), .mirrorX(mirrorX), .animDone(done_c), .pix(bus_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [10:0] x, input logic [10:0] y, input logic ins);
      bus_a.offsetX = x; bus_a.offsetY = y; bus_a.InsideRectangle = ins;
      bus_b.offsetX = x; bus_b.offsetY = y; bus_b.InsideRectangle = ins;
      bus_c.offsetX = x; bus_c.offsetY = y; bus_c.InsideRectangle = ins;
   endtask

   // One video-frame tick, then one more clock so the pixel register shows the new frame.
   task automatic pulse_sof();
      sof = 1'b1; step(); sof = 1'b0; step();
   endtask

   task automatic pulse_restart();
      restart = 1'b1; step(); restart = 1'b0; step();
   endtask

   // Pixel at source (row 2, col 5): frame number in bits 7:6, 6'b010101 below.
   function automatic logic [7:0] frame_rgb(input int f);
      logic [1:0] fb;
      fb = f[1:0];
      return {fb, 6'h15};
   endfunction

   task automatic test_reset();
      resetN = 1'b0; sof = 1'b0; hide = 1'b0; restart = 1'b0; hit = 1'b0;
      mirrorX = 1'b0; mode = 2'b00;
      set_pix(11'd10, 11'd4, 1'b1);
      repeat (3) step();
      n_cmp++;
      if (bus_a.RGBout !== 8'hFF) begin n_mis++; $display("FAIL reset_rgb: got %h want ff", bus_a.RGBout); end
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b0) begin n_mis++; $display("FAIL reset_req: got %b want 0", bus_a.drawingRequest); end
      n_cmp++;
      if (done_a !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", done_a); end
      resetN = 1'b1;
      step();
      n_cmp++;
      if (bus_a.RGBout !== 8'h15) begin n_mis++; $display("FAIL post_reset_rgb: got %h want 15", bus_a.RGBout); end
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b1) begin n_mis++; $display("FAIL post_reset_req: got %b want 1", bus_a.drawingRequest); end
   endtask

   task automatic test_loop();
      int exp_f [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      mode = 2'b01;
      pulse_restart();
      for (int i = 0; i < 9; i++) begin
         pulse_sof();
         n_cmp++;
         if (bus_a.RGBout !== frame_rgb(exp_f[i])) begin
            n_mis++; $display("FAIL loop_frame[%0d]: got %h want %h", i, bus_a.RGBout, frame_rgb(exp_f[i]));
         end
      end
      // Advance to frame 1 (hold count 1), then restart together with a tick.
      repeat (3) pulse_sof();
      restart = 1'b1; sof = 1'b1; step(); restart = 1'b0; sof = 1'b0; step();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(0)) begin n_mis++; $display("FAIL restart_wins: got %h want %h", bus_a.RGBout, frame_rgb(0)); end
      repeat (3) pulse_sof();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(1)) begin n_mis++; $display("FAIL loop_resume: got %h want %h", bus_a.RGBout, frame_rgb(1)); end
      mode = 2'b00;
      pulse_sof();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(0)) begin n_mis++; $display("FAIL static_idle: got %h want %h", bus_a.RGBout, frame_rgb(0)); end
   endtask

   task automatic test_pingpong();
      int exp_f [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      mode = 2'b10;
      pulse_restart();
      for (int i = 0; i < 8; i++) begin
         pulse_sof();
         n_cmp++;
         if (bus_b.RGBout !== frame_rgb(exp_f[i])) begin
            n_mis++; $display("FAIL pingpong_frame[%0d]: got %h want %h", i, bus_b.RGBout, frame_rgb(exp_f[i]));
         end
      end
   endtask

   task automatic test_oneshot();
      int   exp_f  [5] = '{0, 1, 2, 3, 3};
      logic exp_db [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic exp_dc [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      mode = 2'b11;
      pulse_restart();
      for (int i = 0; i < 5; i++) begin
         pulse_sof();
         n_cmp++;
         if (bus_b.RGBout !== frame_rgb(exp_f[i])) begin
            n_mis++; $display("FAIL oneshot_frame[%0d]: got %h want %h", i, bus_b.RGBout, frame_rgb(exp_f[i]));
         end
         n_cmp++;
         if (done_b !== exp_db[i]) begin n_mis++; $display("FAIL oneshot_done[%0d]: got %b want %b", i, done_b, exp_db[i]); end
         n_cmp++;
         if (done_c !== exp_dc[i]) begin n_mis++; $display("FAIL single_done[%0d]: got %b want %b", i, done_c, exp_dc[i]); end
         n_cmp++;
         if (bus_c.RGBout !== frame_rgb(0)) begin n_mis++; $display("FAIL single_frame[%0d]: got %h want 15", i, bus_c.RGBout); end
      end
      pulse_restart();
      n_cmp++;
      if (done_b !== 1'b0) begin n_mis++; $display("FAIL restart_done: got %b want 0", done_b); end
      n_cmp++;
      if (bus_b.RGBout !== frame_rgb(0)) begin n_mis++; $display("FAIL restart_frame: got %h want %h", bus_b.RGBout, frame_rgb(0)); end
   endtask

   task automatic test_blink();
      mode = 2'b00;
      pulse_sof();
      hit = 1'b1; step(); hit = 1'b0; step();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b1) begin n_mis++; $display("FAIL blink_load: got %b want 1", bus_a.drawingRequest); end
      // After tick k the count is 8-k: blanked for counts 7..4, i.e. k = 1..4.
      for (int k = 1; k <= 9; k++) begin
         logic want;
         pulse_sof();
         want = !(k >= 1 && k <= 4);
         n_cmp++;
         if (bus_a.drawingRequest !== want) begin
            n_mis++; $display("FAIL blink_tick[%0d]: got %b want %b", k, bus_a.drawingRequest, want);
         end
      end
      hit = 1'b1; step(); hit = 1'b0; step();
      repeat (2) pulse_sof();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b0) begin n_mis++; $display("FAIL blink_six: got %b want 0", bus_a.drawingRequest); end
      hit = 1'b1; step(); hit = 1'b0; step();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b1) begin n_mis++; $display("FAIL blink_reload: got %b want 1", bus_a.drawingRequest); end
      pulse_sof();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b0) begin n_mis++; $display("FAIL blink_extend: got %b want 0", bus_a.drawingRequest); end
      repeat (7) pulse_sof();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b1) begin n_mis++; $display("FAIL blink_end: got %b want 1", bus_a.drawingRequest); end
   endtask

   task automatic test_hide();
      mode = 2'b01;
      pulse_restart();
      hide = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         pulse_sof();
         n_cmp++;
         if (bus_a.drawingRequest !== 1'b0) begin n_mis++; $display("FAIL hide_req[%0d]: got %b want 0", i, bus_a.drawingRequest); end
      end
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(1)) begin n_mis++; $display("FAIL hide_frame: got %h want %h", bus_a.RGBout, frame_rgb(1)); end
      hide = 1'b0;
      step();
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b1) begin n_mis++; $display("FAIL unhide_req: got %b want 1", bus_a.drawingRequest); end
      mode = 2'b00;
      pulse_sof();
   endtask

   // New pixel every clock; each result must appear exactly one clock later.
   task automatic test_back_to_back();
      logic [10:0] vx   [9] = '{11'd10, 11'd11, 11'd28, 11'd32, 11'd10, 11'd8, 11'd10, 11'd0,  11'd30};
      logic [10:0] vy   [9] = '{11'd4,  11'd5,  11'd30, 11'd4,  11'd32, 11'd8, 11'd4,  11'd4,  11'd28};
      logic        vin  [9] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,  1'b0,   1'b1,   1'b1};
      logic [7:0]  wrgb [9] = '{8'h15,  8'h15,  8'h3E,  8'hFF,  8'hFF,  8'hFF, 8'hFF,  8'h10,  8'h37};
      logic        wreq [9] = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0,  1'b0,   1'b1,   1'b1};
      for (int i = 0; i < 9; i++) begin
         set_pix(vx[i], vy[i], vin[i]);
         step();
         n_cmp++;
         if (bus_a.RGBout !== wrgb[i]) begin n_mis++; $display("FAIL pix_rgb[%0d]: got %h want %h", i, bus_a.RGBout, wrgb[i]); end
         n_cmp++;
         if (bus_a.drawingRequest !== wreq[i]) begin
            n_mis++; $display("FAIL pix_req[%0d]: got %b want %b", i, bus_a.drawingRequest, wreq[i]);
         end
      end
   endtask

   task automatic test_mirror();
      logic [7:0] want0, want30;
`ifdef SPRITE_MIRROR_EN
      want0 = 8'h17; want30 = 8'h10;
`else
      want0 = 8'h10; want30 = 8'h17;
`endif
      mirrorX = 1'b1;
      set_pix(11'd0, 11'd4, 1'b1);
      step();
      n_cmp++;
      if (bus_a.RGBout !== want0) begin n_mis++; $display("FAIL mirror_x0: got %h want %h", bus_a.RGBout, want0); end
      set_pix(11'd30, 11'd4, 1'b1);
      step();
      n_cmp++;
      if (bus_a.RGBout !== want30) begin n_mis++; $display("FAIL mirror_x30: got %h want %h", bus_a.RGBout, want30); end
      mirrorX = 1'b0;
      set_pix(11'd10, 11'd4, 1'b1);
      step();
   endtask

   task automatic test_async_reset();
      mode = 2'b01;
      pulse_restart();
      repeat (3) pulse_sof();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(1)) begin n_mis++; $display("FAIL pre_areset: got %h want %h", bus_a.RGBout, frame_rgb(1)); end
      #2 resetN = 1'b0;
      #1;
      n_cmp++;
      if (bus_a.RGBout !== 8'hFF) begin n_mis++; $display("FAIL areset_rgb: got %h want ff", bus_a.RGBout); end
      n_cmp++;
      if (bus_a.drawingRequest !== 1'b0) begin n_mis++; $display("FAIL areset_req: got %b want 0", bus_a.drawingRequest); end
      step();
      resetN = 1'b1;
      step();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(0)) begin n_mis++; $display("FAIL areset_frame0: got %h want %h", bus_a.RGBout, frame_rgb(0)); end
      repeat (3) pulse_sof();
      n_cmp++;
      if (bus_a.RGBout !== frame_rgb(1)) begin n_mis++; $display("FAIL areset_resume: got %h want %h", bus_a.RGBout, frame_rgb(1)); end
   endtask

   initial begin
      test_reset();
      test_loop();
      test_pingpong();
      test_oneshot();
      test_blink();
      test_hide();
      test_back_to_back();
      test_mirror();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
